mvd_bits_multi_est: RTL



---
 rtl/mvd_bits_multi_est.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mvd_bits_multi_est.sv
// ---------------------------------------------------------------------------
// mvd_bits_multi_est
//   Three-stage pipelined MVD bit estimator. For every input beat it works out
//   the signed Exp-Golomb length of (mv - cand) for each MVP candidate. It
//   then picks the cheapest valid candidate, with ties going to the lower
//   index, and keeps a saturating running bit total for each PU.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_valid_i    input beat valid;  in_ready_o  input beat accepted
//   in_last_i     last MV of the current PU
//   mv_i          {y,x} signed quarter-pel MV
//   cand_i        candidate k at [k*2*FMV_WIDTH +: 2*FMV_WIDTH], {y,x}
//   cand_vld_i    per-candidate availability
//   out_valid_o   result valid;      out_ready_i downstream accepts result
//   out_last_o    in_last_i of this beat
//   out_idx_o     selected candidate index
//   out_bits_o    len_x + len_y of the selected candidate
//   mvd_o         {y,x} of mv minus the selected candidate
//   acc_bits_o    running PU sum including this beat
// ---------------------------------------------------------------------------
module mvd_bits_multi_est #(
  parameter  int FMV_WIDTH  = 10,
  parameter  int NUM_CAND   = 2,
  parameter  int LEN_MAX    = 63,
  parameter  int ACC_WIDTH  = 10,
  localparam int MVD_WIDTH  = FMV_WIDTH + 1,
  localparam int BITS_WIDTH = 7,
  localparam int IDX_WIDTH  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic                            in_last_i,
  input  logic [2*FMV_WIDTH-1:0]          mv_i,
  input  logic [NUM_CAND*2*FMV_WIDTH-1:0] cand_i,
  input  logic [NUM_CAND-1:0]             cand_vld_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            out_last_o,
  output logic [IDX_WIDTH-1:0]            out_idx_o,
  output logic [BITS_WIDTH-1:0]           out_bits_o,
  output logic [2*MVD_WIDTH-1:0]          mvd_o,
  output logic [ACC_WIDTH-1:0]            acc_bits_o
);

  localparam int LEN_WIDTH = $clog2(LEN_MAX + 1);
  localparam int U1_WIDTH  = MVD_WIDTH + 2;  // holds u+1 for the widest d

  typedef logic [MVD_WIDTH-1:0] mvd_t;
  typedef logic [LEN_WIDTH-1:0] len_t;

  // Signed Exp-Golomb length: 2*floor(log2(u+1)) + 1, where u maps d onto
  // 0, 1, 2, ... as 0, +1, -1, +2, -2, ...
  function automatic len_t comp_len(input mvd_t d);
    logic [U1_WIDTH-1:0] d_ext;
    logic [U1_WIDTH-1:0] u1;
    logic                pos;
    int                  p;
    int                  len;
    d_ext = {{2{d[MVD_WIDTH-1]}}, d};
    pos   = !d[MVD_WIDTH-1] && (d != '0);
    // u+1 is 2d for d>0 and 1-2d otherwise
    u1    = pos ? (d_ext << 1) : ((U1_WIDTH'(0) - (d_ext << 1)) + U1_WIDTH'(1));
    p     = 0;
    for (int i = 0; i < U1_WIDTH; i++) begin
      if (u1[i]) p = i;
    end
    len = 2 * p + 1;
    if (len > LEN_MAX) len = LEN_MAX;
    return len_t'(len);
  endfunction

  // ---------------- handshake chain ----------------
  logic s1_valid, s2_valid, s3_valid;
  logic s1_en, s2_en, s3_en;

  assign s3_en      = !s3_valid || out_ready_i;
  assign s2_en      = !s2_valid || s3_en;
  assign s1_en      = !s1_valid || s2_en;
  assign in_ready_o = s1_en;
  assign out_valid_o = s3_valid;

  // ---------------- S1: differences ----------------
  mvd_t                s1_dx [NUM_CAND];
  mvd_t                s1_dy [NUM_CAND];
  logic [NUM_CAND-1:0] s1_vld;
  logic                s1_last;

  mvd_t in_dx [NUM_CAND];
  mvd_t in_dy [NUM_CAND];

  always_comb begin
    for (int k = 0; k < NUM_CAND; k++) begin
      logic [FMV_WIDTH-1:0] cx, cy, mx, my;
      mx = mv_i[0 +: FMV_WIDTH];
      my = mv_i[FMV_WIDTH +: FMV_WIDTH];
      cx = cand_i[k*2*FMV_WIDTH +: FMV_WIDTH];
      cy = cand_i[k*2*FMV_WIDTH + FMV_WIDTH +: FMV_WIDTH];
      in_dx[k] = {mx[FMV_WIDTH-1], mx} - {cx[FMV_WIDTH-1], cx};
      in_dy[k] = {my[FMV_WIDTH-1], my} - {cy[FMV_WIDTH-1], cy};
    end
  end

  // ---------------- S2: lengths ----------------
  len_t                s2_lx [NUM_CAND];
  len_t                s2_ly [NUM_CAND];
  mvd_t                s2_dx [NUM_CAND];
  mvd_t                s2_dy [NUM_CAND];
  logic [NUM_CAND-1:0] s2_vld;
  logic                s2_last;

  // NOTE: datapath registers behind a valid bit carry no reset; only the valid
  // flags and the visible outputs need a known value after rst.
  always_ff @(posedge clk) begin
    if (s1_en && in_valid_i) begin
      s1_dx   <= in_dx;
      s1_dy   <= in_dy;
      s1_vld  <= cand_vld_i;
      s1_last <= in_last_i;
    end
    if (s2_en && s1_valid) begin
      for (int k = 0; k < NUM_CAND; k++) begin
        s2_lx[k] <= comp_len(s1_dx[k]);
        s2_ly[k] <= comp_len(s1_dy[k]);
      end
      s2_dx   <= s1_dx;
      s2_dy   <= s1_dy;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
    end
  end

  // ---------------- S3 input: sum, argmin, accumulate ----------------
  logic [BITS_WIDTH-1:0] cost [NUM_CAND];
  logic [BITS_WIDTH-1:0] sel_cost;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic                  found;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH:0]    acc_sum;
  logic [ACC_WIDTH-1:0]  acc_next;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int k = 0; k < NUM_CAND; k++) begin
      cost[k] = BITS_WIDTH'(s2_lx[k]) + BITS_WIDTH'(s2_ly[k]);
    end
    // With no valid candidate these defaults report candidate 0.
    sel_idx  = '0;
    sel_cost = cost[0];
    found    = 1'b0;
    for (int k = 0; k < NUM_CAND; k++) begin
      // strict < keeps the lowest index on a tie
      if (s2_vld[k] && (!found || cost[k] < sel_cost)) begin
        found    = 1'b1;
        sel_cost = cost[k];
        sel_idx  = IDX_WIDTH'(k);
      end
    end
    acc_sum  = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - BITS_WIDTH){1'b0}}, sel_cost};
    acc_next = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      out_last_o <= 1'b0;
      out_idx_o  <= '0;
      out_bits_o <= '0;
      mvd_o      <= '0;
      acc_bits_o <= '0;
      acc_q      <= '0;
    end else begin
      if (s1_en) s1_valid <= in_valid_i;
      if (s2_en) s2_valid <= s1_valid;
      if (s3_en) begin
        s3_valid <= s2_valid;
        if (s2_valid) begin
          out_last_o <= s2_last;
          out_idx_o  <= sel_idx;
          out_bits_o <= sel_cost;
          mvd_o      <= {s2_dy[sel_idx], s2_dx[sel_idx]};
          acc_bits_o <= acc_next;
          // a closing beat restarts the PU total at zero
          acc_q      <= s2_last ? '0 : acc_next;
        end
      end
    end
  end

endmodule
